alu_issue_ctrl: RTL and testbench

//  Upstream issue/retire controller for the registered ALU timing stage. Buffers operation

---
 rtl/alu_issue_ctrl_if.sv | 25 ++
 rtl/alu_issue_ctrl.sv | 133 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Command and result handshake channels of the ALU issue/retire controller.
// master = command producer / result consumer, slave = the controller.
interface alu_issue_ctrl_if #(
    parameter int N = 32
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_s;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;
    logic [3:0]   res_flags;

    modport master (
        output cmd_valid, cmd_s, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_flags
    );

    modport slave (
        input  cmd_valid, cmd_s, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_flags
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/retire controller for a fixed-latency, non-stallable ALU stage.
// Commands queue in a FIFO and issue at most one per cycle. Issue is credit
// based: an op only leaves the command FIFO if its result is guaranteed a
// slot in the result FIFO (queued results + ops in flight < RDEPTH).
module alu_issue_ctrl #(
    parameter int N      = 32,
    parameter int CDEPTH = 4,
    parameter int RDEPTH = 4,
    parameter int LAT    = 2
) (
    input  logic            clk,
    input  logic            rst,
    alu_issue_ctrl_if.slave bus,
    output logic [3:0]      alu_s,
    output logic [N-1:0]    alu_a,
    output logic [N-1:0]    alu_b,
    input  logic [N-1:0]    alu_result,
    input  logic [3:0]      alu_flags,
    output logic            busy
);
    localparam int CAW = $clog2(CDEPTH);
    localparam int CCW = CAW + 1;
    localparam int RAW = $clog2(RDEPTH);
    localparam int RCW = RAW + 1;
    localparam int IW  = $clog2(LAT + 2);

    logic [3:0]   cmd_s_mem [CDEPTH];
    logic [N-1:0] cmd_a_mem [CDEPTH];
    logic [N-1:0] cmd_b_mem [CDEPTH];
    logic [CAW-1:0] cmd_wr_ptr;
    logic [CAW-1:0] cmd_rd_ptr;
    logic [CCW-1:0] cmd_count;

    logic [N-1:0] res_data_mem  [RDEPTH];
    logic [3:0]   res_flags_mem [RDEPTH];
    logic [RAW-1:0] res_wr_ptr;
    logic [RAW-1:0] res_rd_ptr;
    logic [RCW-1:0] res_count;

    // Bit i set means an op issued i+1 edges ago; the tail bit marks the
    // cycle in which that op's result sits on alu_result/alu_flags.
    logic [LAT:0]   issue_pipe;
    logic [IW-1:0]  inflight;
    logic [31:0]    credit_used;

    logic cmd_push;
    logic issue;
    logic capture;
    logic res_pop;

    assign bus.cmd_ready = (cmd_count != CCW'(CDEPTH));
    assign cmd_push      = bus.cmd_valid && bus.cmd_ready;
    assign credit_used   = 32'(res_count) + 32'(inflight);
    assign issue         = (cmd_count != '0) && (credit_used < 32'(RDEPTH));
    assign capture       = issue_pipe[LAT];
    assign bus.res_valid = (res_count != '0);
    assign res_pop       = bus.res_valid && bus.res_ready;
    assign bus.res_data  = bus.res_valid ? res_data_mem[res_rd_ptr]  : '0;
    assign bus.res_flags = bus.res_valid ? res_flags_mem[res_rd_ptr] : '0;
    assign busy          = (cmd_count != '0) || (inflight != '0) || (res_count != '0);

    // Count ops currently travelling through the ALU stage.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= LAT; i++) begin
            inflight = inflight + IW'(issue_pipe[i]);
        end
    end

    // Command FIFO storage; contents need no reset because count gates use.
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_s_mem[cmd_wr_ptr] <= bus.cmd_s;
            cmd_a_mem[cmd_wr_ptr] <= bus.cmd_a;
            cmd_b_mem[cmd_wr_ptr] <= bus.cmd_b;
        end
    end

    // Command FIFO pointers/count, issue registers and the in-flight pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_count  <= '0;
            alu_s      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            issue_pipe <= '0;
        end else begin
            if (cmd_push) begin
                cmd_wr_ptr <= cmd_wr_ptr + CAW'(1);
            end
            if (issue) begin
                cmd_rd_ptr <= cmd_rd_ptr + CAW'(1);
                alu_s      <= cmd_s_mem[cmd_rd_ptr];
                alu_a      <= cmd_a_mem[cmd_rd_ptr];
                alu_b      <= cmd_b_mem[cmd_rd_ptr];
            end
            cmd_count  <= cmd_count + CCW'(cmd_push) - CCW'(issue);
            issue_pipe <= {issue_pipe[LAT-1:0], issue};
        end
    end

    // Result FIFO storage written when the pipe tail says a result is due.
    always_ff @(posedge clk) begin
        if (capture) begin
            res_data_mem[res_wr_ptr]  <= alu_result;
            res_flags_mem[res_wr_ptr] <= alu_flags;
        end
    end

    // Result FIFO pointers and count; capture and pop may share an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
            res_count  <= '0;
        end else begin
            if (capture) begin
                res_wr_ptr <= res_wr_ptr + RAW'(1);
            end
            if (res_pop) begin
                res_rd_ptr <= res_rd_ptr + RAW'(1);
            end
            res_count <= res_count + RCW'(capture) - RCW'(res_pop);
        end
    end

    // The credit scheme must make a capture into a full result FIFO impossible.
    assert property (@(posedge clk) disable iff (rst)
        !(capture && (res_count == RCW'(RDEPTH)) && !res_pop));

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a stub ALU stage (LAT-register
// echo of a^b, flags = s). Expected results are "a xor b, flags = s" in
// command order; occupancy invariants follow from the total outstanding ops.
module tb_alu_issue_ctrl;
    localparam int N      = 32;
    localparam int CDEPTH = 4;
    localparam int RDEPTH = 4;
    localparam int LAT    = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   alu_s;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic         busy;

    alu_issue_ctrl_if #(.N(N)) bus ();

    alu_issue_ctrl #(
        .N(N), .CDEPTH(CDEPTH), .RDEPTH(RDEPTH), .LAT(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .alu_s(alu_s),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_result(alu_result),
        .alu_flags(alu_flags),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Stub ALU stage: input register then output register, shared reset.
    logic [3:0]   stub_s [LAT];
    logic [N-1:0] stub_v [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                stub_s[i] <= '0;
                stub_v[i] <= '0;
            end
        end else begin
            stub_s[0] <= alu_s;
            stub_v[0] <= alu_a ^ alu_b;
            for (int i = 1; i < LAT; i++) begin
                stub_s[i] <= stub_s[i-1];
                stub_v[i] <= stub_v[i-1];
            end
        end
    end

    assign alu_result = stub_v[LAT-1];
    assign alu_flags  = stub_s[LAT-1];

    typedef struct {
        logic [N-1:0] data;
        logic [3:0]   flags;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    logic stim_done;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: invariants on current state, then handshakes of the coming edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            checkOutput("busy_vs_outstanding", busy, sb.size() != 0);
            if (sb.size() < CDEPTH)
                checkOutput("cmd_ready_room", bus.cmd_ready, 1);
            if (sb.size() >= CDEPTH + RDEPTH)
                checkOutput("cmd_ready_full", bus.cmd_ready, 0);
            if (!bus.res_valid) begin
                checkOutput("empty_res_data", bus.res_data, 0);
                checkOutput("empty_res_flags", bus.res_flags, 0);
            end
            if (bus.res_valid && bus.res_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("res_data", bus.res_data, e.data);
                    checkOutput("res_flags", bus.res_flags, e.flags);
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                e.data  = bus.cmd_a ^ bus.cmd_b;
                e.flags = bus.cmd_s;
                sb.push_back(e);
            end
        end
    end

    // Present one command and hold it until accepted; entered just after a rising edge.
    task automatic applyStimulus(input logic [3:0] s, input logic [N-1:0] a,
                                 input logic [N-1:0] b);
        int waited = 0;
        bus.cmd_s     = s;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        while (!bus.cmd_ready && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.cmd_ready)
            checkOutput("cmd_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic applyRandom();
        applyStimulus(4'($urandom_range(0, 15)), N'($urandom), N'($urandom));
    endtask

    task automatic waitDrain(input string name);
        int w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        if (sb.size() != 0)
            checkOutput(name, sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_s     = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.res_ready = 1'b0;
        stim_done     = 1'b0;
        #1;
        checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
        checkOutput("rst_res_valid", bus.res_valid, 0);
        checkOutput("rst_res_data", bus.res_data, 0);
        checkOutput("rst_res_flags", bus.res_flags, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_alu_s", alu_s, 0);
        checkOutput("rst_alu_a", alu_a, 0);
        checkOutput("rst_alu_b", alu_b, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single op latency");
        applyStimulus(4'h3, 32'h0000_00F0, 32'h0000_000F);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("t2_not_yet_valid", bus.res_valid, 0);
        end
        @(posedge clk);
        #1;
        checkOutput("t2_res_valid", bus.res_valid, 1);
        checkOutput("t2_res_data", bus.res_data, 32'h0000_00FF);
        checkOutput("t2_res_flags", bus.res_flags, 4'h3);
        bus.res_ready = 1'b1;
        waitDrain("t2_drain_timeout");

        $display("[TB] streaming");
        for (int i = 0; i < 8; i++) applyRandom();
        waitDrain("t3_drain_timeout");

        $display("[TB] backpressure and full command queue");
        bus.res_ready = 1'b0;
        for (int i = 0; i < 8; i++) applyRandom();
        repeat (8) @(posedge clk);
        #1;
        checkOutput("t4_cmd_ready_low", bus.cmd_ready, 0);
        checkOutput("t4_res_valid", bus.res_valid, 1);
        checkOutput("t4_busy", busy, 1);
        checkOutput("t4_head_data", bus.res_data, sb[0].data);
        fork
            applyRandom();
            bus.res_ready = 1'b1;
        join
        waitDrain("t4_drain_timeout");

        $display("[TB] random traffic with random backpressure");
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int gap = $urandom_range(0, 2);
                    repeat (gap) begin
                        @(posedge clk);
                        #1;
                    end
                    applyRandom();
                end
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1;
                    bus.res_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.res_ready = 1'b1;
        waitDrain("t5_drain_timeout");

        $display("[TB] reset with ops in flight");
        bus.res_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyRandom();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t1_alu_s", alu_s, 0);
        checkOutput("t1_alu_a", alu_a, 0);
        checkOutput("t1_alu_b", alu_b, 0);
        checkOutput("t1_res_valid", bus.res_valid, 0);
        checkOutput("t1_res_data", bus.res_data, 0);
        checkOutput("t1_res_flags", bus.res_flags, 0);
        checkOutput("t1_cmd_ready", bus.cmd_ready, 1);
        checkOutput("t1_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            checkOutput("t1_no_stale_valid", bus.res_valid, 0);
        end
        checkOutput("t1_idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
